div_unit: RTL

//  Multi-cycle radix-2 restoring divider for DIV/DIVU.

---
 rtl/div_if.sv | 28 ++
 rtl/div_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/div_if.sv
// div_if: handshake/data bundle between the EX stage and the divider.
//   master (EX side)    : drives signed_div_i, opdata1_i, opdata2_i, start_i, annul_i
//                         and receives result_o, ready_o, busy_o
//   slave (div_unit side): the mirror image
// Signal names keep the divider's port naming, so the _i/_o suffixes are
// relative to the divider.
interface div_if #(
  parameter int WIDTH = 32
) ();
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
//   clk   : clock, rising edge
//   rst   : synchronous, active-high reset
//   bus   : div_if.slave
//           signed_div_i  1 = signed, 0 = unsigned
//           opdata1_i     dividend (sampled when start is accepted)
//           opdata2_i     divisor  (sampled when start is accepted)
//           start_i       request, held until ready_o is seen
//           annul_i       abort division (flush)
//           result_o      {remainder, quotient}, registered
//           ready_o       result valid, registered
//           busy_o        high in ON and BYZERO (decoded from state)
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, result forced to 0
// ON     | one restoring iteration per cycle, then sign fix-up
// END    | result held until start_i drops
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  // {remainder, quotient} working register. Together with the bit that is
  // shifted out of the top on every step (the MSB of trial's minuend) it
  // forms the 2*WIDTH+1 bit restoring shift register.
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     dvs_q;
  logic                 neg1_q;
  logic                 neg2_q;
  logic                 sgn_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic [WIDTH-1:0]     abs1;
  logic [WIDTH-1:0]     abs2;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    abs1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // Shift left by one, then try to subtract the divisor from the upper
    // WIDTH+1 bits; a borrow (trial MSB) means restore, i.e. keep the shift.
    trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
    if (trial[WIDTH])
      acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    else
      acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = (sgn_q && neg1_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state_q <= S_BYZERO;
            end else begin
              state_q <= S_ON;
              cnt_q   <= '0;
              acc_q   <= {{WIDTH{1'b0}}, abs1};
              dvs_q   <= abs2;
              neg1_q  <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
              neg2_q  <= bus.signed_div_i & bus.opdata2_i[WIDTH-1];
              sgn_q   <= bus.signed_div_i;
            end
          end
        end
        S_BYZERO: begin
          if (bus.annul_i) begin
            state_q <= S_FREE;
          end else begin
            state_q  <= S_END;
            result_q <= '0;
            ready_q  <= 1'b1;
          end
        end
        S_ON: begin
          if (bus.annul_i) begin
            state_q <= S_FREE;
          end else if (cnt_q != CNT_W'(WIDTH)) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
        end
        S_END: begin
          if (!bus.start_i) begin
            state_q  <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = (state_q == S_ON) || (state_q == S_BYZERO);

endmodule
